// File: rtl/rx_bit_recovery.sv
// rx_bit_recovery: USB full-speed receive bit recovery behind the D+ edge detector.
// Tracks bit phase at CLKS_PER_BIT clocks per bit, resyncing on every line edge,
// samples at SAMPLE_POINT, NRZI-decodes, strips stuffed bits and strobes the shifter.
// Build option RX_STUFF_CHECK_EN: a 1 found in a stuffed-bit slot pulses stuff_err
// and discards the partial byte. Left undefined, the stuffed slot is dropped silently
// and stuff_err is tied low.
module rx_bit_recovery #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus_sync,
    input  logic d_edge,
    input  logic rcving,
    output logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);

    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);

    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [OW-1:0] ones_cnt_q, ones_cnt_d;
    logic          prev_line_q, prev_line_d;
    logic          d_orig_q, d_orig_d;
    logic          shift_enable_q, shift_enable_d;
    logic          byte_received_q, byte_received_d;
`ifdef RX_STUFF_CHECK_EN
    logic          stuff_err_q, stuff_err_d;
`endif

    logic sample_ev;
    logic dec;

    // The sample decision uses the current phase, so an edge landing on the sample
    // point still samples this cycle while also reloading the phase.
    assign sample_ev = rcving && (phase_q == PH_SAMPLE);
    assign dec       = (d_plus_sync == prev_line_q);

    // Next-state: phase tracking, NRZI decode, unstuffing and strobe generation.
    always_comb begin
        phase_d         = phase_q;
        bit_cnt_d       = bit_cnt_q;
        ones_cnt_d      = ones_cnt_q;
        prev_line_d     = prev_line_q;
        d_orig_d        = d_orig_q;
        shift_enable_d  = 1'b0;
        byte_received_d = 1'b0;
`ifdef RX_STUFF_CHECK_EN
        stuff_err_d     = 1'b0;
`endif
        if (!rcving) begin
            phase_d     = '0;
            bit_cnt_d   = '0;
            ones_cnt_d  = '0;
            prev_line_d = 1'b1;
            d_orig_d    = 1'b1;
        end else begin
            // bit_cnt has already wrapped to 0 when the 8th strobe is out.
            byte_received_d = shift_enable_q && (bit_cnt_q == 3'd0);

            // The edge cycle counts as phase 0, so the next cycle is phase 1.
            if (d_edge) begin
                phase_d = PW'(1);
            end else if (phase_q == PH_LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end

            if (sample_ev) begin
                prev_line_d = d_plus_sync;
                if (ones_cnt_q < ONES_MAX) begin
                    shift_enable_d = 1'b1;
                    d_orig_d       = dec;
                    ones_cnt_d     = dec ? (ones_cnt_q + OW'(1)) : '0;
                    bit_cnt_d      = bit_cnt_q + 3'd1;
                end else begin
                    ones_cnt_d = '0;
`ifdef RX_STUFF_CHECK_EN
                    if (dec) begin
                        stuff_err_d = 1'b1;
                        bit_cnt_d   = '0;
                    end
`endif
                end
            end
        end
    end

    // State registers with synchronous reset back to idle-J.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q         <= '0;
            bit_cnt_q       <= '0;
            ones_cnt_q      <= '0;
            prev_line_q     <= 1'b1;
            d_orig_q        <= 1'b1;
            shift_enable_q  <= 1'b0;
            byte_received_q <= 1'b0;
`ifdef RX_STUFF_CHECK_EN
            stuff_err_q     <= 1'b0;
`endif
        end else begin
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            ones_cnt_q      <= ones_cnt_d;
            prev_line_q     <= prev_line_d;
            d_orig_q        <= d_orig_d;
            shift_enable_q  <= shift_enable_d;
            byte_received_q <= byte_received_d;
`ifdef RX_STUFF_CHECK_EN
            stuff_err_q     <= stuff_err_d;
`endif
        end
    end

    assign d_orig        = d_orig_q;
    assign shift_enable  = shift_enable_q;
    assign byte_received = byte_received_q;
`ifdef RX_STUFF_CHECK_EN
    assign stuff_err     = stuff_err_q;
`else
    assign stuff_err     = 1'b0;
`endif

endmodule
